// File: rtl/hub75_scan_driver.sv
// HUB75 1-bpp scan driver for a 64x64 panel: reads row pairs from panel memory,
// thresholds each pixel, shifts them out, then blanks, latches and displays the row.
module hub75_scan_driver #(
  parameter int COLS    = 64,
  parameter int ROWS    = 64,
  parameter int ADDR_W  = 12,
  parameter int CLK_DIV = 4,
  parameter int THRESH  = 128,
  parameter int DEAD    = 2,
  parameter int LAT_W   = 2,
  parameter int ON_TIME = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] addr_top,
  output logic [ADDR_W-1:0] addr_bottom,
  input  logic [23:0]       pix_top,
  input  logic [23:0]       pix_bottom,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              r2,
  output logic              g2,
  output logic              b2,
  output logic              sclk,
  output logic              lat,
  output logic              oe_n,
  output logic [$clog2(ROWS/2)-1:0] row_addr,
  output logic              frame_start
);

  // state   | meaning
  // IDLE    | panel dark, waiting for en
  // SHIFT   | COLS slots of 2*CLK_DIV cycles, one pixel pair per slot
  // BLANK   | oe_n high for DEAD cycles before the latch
  // LATCH   | lat high for LAT_W cycles, row_addr updated
  // DISPLAY | oe_n low for ON_TIME cycles, then advance row

  localparam int HALF = ROWS / 2;
  localparam int RW   = $clog2(HALF);
  localparam int CW   = $clog2(COLS);
  localparam int PW   = $clog2(2 * CLK_DIV);
  localparam int TW   = $clog2(ON_TIME + DEAD + LAT_W + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_BLANK   = 3'd2,
    S_LATCH   = 3'd3,
    S_DISPLAY = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          first_latch;
  logic          phase_last;
  logic          col_last;

  assign phase_last = (phase == PW'(2 * CLK_DIV - 1));
  assign col_last   = (col == CW'(COLS - 1));

  function automatic logic [ADDR_W-1:0] addr_of(input logic [RW-1:0] r,
                                                 input logic [CW-1:0] c,
                                                 input logic          lower);
    int a;
    a = (int'(r) + (lower ? HALF : 0)) * COLS + int'(c);
    return ADDR_W'(a);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= '0;
      col         <= '0;
      row         <= '0;
      timer       <= '0;
      first_latch <= 1'b0;
      row_addr    <= '0;
      addr_top    <= '0;
      addr_bottom <= '0;
      {r1, g1, b1, r2, g2, b2} <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      timer <= timer_nxt;
      if (state != S_LATCH && state_nxt == S_LATCH) begin
        row_addr    <= row;
        first_latch <= 1'b1;
      end
      // Address lands in p=0 so the registered memory data is ready in p=1.
      if (state_nxt == S_SHIFT && phase_nxt == '0) begin
        addr_top    <= addr_of(row_nxt, col_nxt, 1'b0);
        addr_bottom <= addr_of(row_nxt, col_nxt, 1'b1);
      end
      if (state == S_SHIFT && phase == PW'(1)) begin
        r1 <= (pix_top[23:16]    >= 8'(THRESH));
        g1 <= (pix_top[15:8]     >= 8'(THRESH));
        b1 <= (pix_top[7:0]      >= 8'(THRESH));
        r2 <= (pix_bottom[23:16] >= 8'(THRESH));
        g2 <= (pix_bottom[15:8]  >= 8'(THRESH));
        b2 <= (pix_bottom[7:0]   >= 8'(THRESH));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    col_nxt   = col;
    row_nxt   = row;
    timer_nxt = (timer != '0) ? timer - TW'(1) : '0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_SHIFT;
          phase_nxt = '0;
          col_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (phase_last) begin
          phase_nxt = '0;
          col_nxt   = col_last ? '0 : col + CW'(1);
          if (col_last) begin
            state_nxt = S_BLANK;
            timer_nxt = TW'(DEAD - 1);
          end
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      S_BLANK: begin
        if (timer == '0) begin
          state_nxt = S_LATCH;
          timer_nxt = TW'(LAT_W - 1);
        end
      end
      S_LATCH: begin
        if (timer == '0) begin
          state_nxt = S_DISPLAY;
          timer_nxt = TW'(ON_TIME - 1);
        end
      end
      S_DISPLAY: begin
        if (timer == '0) begin
          row_nxt   = (row == RW'(HALF - 1)) ? '0 : row + RW'(1);
          phase_nxt = '0;
          col_nxt   = '0;
          state_nxt = en ? S_SHIFT : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oe_n        = 1'b1;
    sclk        = 1'b0;
    lat         = 1'b0;
    frame_start = 1'b0;
    case (state)
      S_SHIFT: begin
        // Keep the previously latched row lit while the next one shifts in.
        oe_n        = ~first_latch;
        sclk        = (phase >= PW'(CLK_DIV));
        frame_start = (row == '0) && (col == '0) && (phase == '0);
      end
      S_LATCH:   lat  = 1'b1;
      S_DISPLAY: oe_n = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with a 1-cycle-latency memory model.
module tb_hub75_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] addr_top, addr_bottom;
  logic [23:0] pix_top, pix_bottom;
  logic        r1, g1, b1, r2, g2, b2;
  logic        sclk, lat, oe_n, frame_start;
  logic [4:0]  row_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hub75_scan_driver dut (
    .clk(clk), .rst(rst), .en(en),
    .addr_top(addr_top), .addr_bottom(addr_bottom),
    .pix_top(pix_top), .pix_bottom(pix_bottom),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .sclk(sclk), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .frame_start(frame_start)
  );

  function automatic logic [23:0] pix_of(input logic [11:0] a);
    if (a == 12'd5)    return 24'h807FFF;
    if (a == 12'd2053) return 24'h7F8000;
    return {a[0] ? 8'hFF : 8'h00, a[1] ? 8'h80 : 8'h7F, a[2] ? 8'hC0 : 8'h10};
  endfunction

  function automatic logic [2:0] bits_of(input logic [11:0] a);
    logic [23:0] p;
    p = pix_of(a);
    return {p[23:16] >= 8'd128, p[15:8] >= 8'd128, p[7:0] >= 8'd128};
  endfunction

  always @(posedge clk) begin
    pix_top    <= pix_of(addr_top);
    pix_bottom <= pix_of(addr_bottom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_row(input int row);
    logic [11:0] at, ab;
    for (int c = 0; c < 64; c++) begin
      at = 12'(row * 64 + c);
      ab = 12'((row + 32) * 64 + c);
      chk("addr_top", addr_top, at);
      chk("addr_bottom", addr_bottom, ab);
      step(3);
      chk("sclk_low_p3", sclk, 0);
      step(1);
      chk("sclk_high_p4", sclk, 1);
      chk("rgb", {r1, g1, b1, r2, g2, b2}, {bits_of(at), bits_of(ab)});
      if (row == 0 && c == 5) chk("rgb_col5", {r1, g1, b1, r2, g2, b2}, 6'b101010);
      step(4);
    end
  endtask

  task automatic tail(input int row);
    logic [11:0] a0;
    int n;
    chk("blank1_sclk", sclk, 0);
    chk("blank1_oe_n", oe_n, 1);
    chk("blank1_lat", lat, 0);
    step(1);
    chk("blank2_oe_n", oe_n, 1);
    chk("blank2_lat", lat, 0);
    step(1);
    chk("latch1_lat", lat, 1);
    chk("latch1_oe_n", oe_n, 1);
    chk("latch_row_addr", row_addr, row);
    step(1);
    chk("latch2_lat", lat, 1);
    step(1);
    chk("disp_lat", lat, 0);
    chk("disp_oe_n", oe_n, 0);
    a0 = addr_top;
    n = 0;
    while (oe_n === 1'b0 && addr_top === a0 && n < 2000) begin
      n++;
      step(1);
    end
    chk("display_cycles", n, 256);
  endtask

  task automatic wait_addr(input logic [11:0] target, input int budget);
    int n;
    n = 0;
    while (addr_top !== target && n < budget) begin
      n++;
      step(1);
    end
    chk("wait_addr", addr_top, target);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    en  = 1'b0;
    step(3);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_lat", lat, 0);
    chk("rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    chk("rst_addr_top", addr_top, 0);
    chk("rst_addr_bottom", addr_bottom, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_row_addr", row_addr, 0);

    rst = 1'b0;
    en  = 1'b1;
    step(1);
    chk("start_frame_start", frame_start, 1);
    chk("start_oe_n", oe_n, 1);
    shift_row(0);
    tail(0);
    chk("row1_addr_top", addr_top, 64);
    chk("row1_oe_n", oe_n, 0);
    chk("row1_frame_start", frame_start, 0);

    wait_addr(12'd1984, 30000);
    shift_row(31);
    tail(31);
    chk("wrap_addr_top", addr_top, 0);
    chk("wrap_addr_bottom", addr_bottom, 2048);
    chk("wrap_frame_start", frame_start, 1);
    chk("wrap_row_addr", row_addr, 31);
    step(1);
    chk("wrap_frame_start_pulse", frame_start, 0);

    wait_addr(12'd192, 3000);
    step(100);
    en = 1'b0;
    n = 0;
    while (lat !== 1'b1 && n < 1000) begin
      n++;
      step(1);
    end
    chk("drop_lat", lat, 1);
    chk("drop_row_addr", row_addr, 3);
    step(2);
    chk("drop_disp_oe_n", oe_n, 0);
    n = 0;
    while (oe_n === 1'b0 && n < 2000) begin
      n++;
      step(1);
    end
    chk("drop_display_cycles", n, 256);
    step(50);
    chk("idle_oe_n", oe_n, 1);
    chk("idle_sclk", sclk, 0);
    chk("idle_lat", lat, 0);
    chk("idle_addr_top", addr_top, 255);
    en = 1'b1;
    step(1);
    chk("resume_addr_top", addr_top, 256);
    chk("resume_addr_bottom", addr_bottom, 2304);
    chk("resume_frame_start", frame_start, 0);
    chk("resume_oe_n", oe_n, 0);

    step(20);
    rst = 1'b1;
    #1;
    chk("arst_oe_n", oe_n, 1);
    chk("arst_sclk", sclk, 0);
    chk("arst_lat", lat, 0);
    chk("arst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    chk("arst_addr_top", addr_top, 0);
    chk("arst_addr_bottom", addr_bottom, 0);
    chk("arst_row_addr", row_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("restart_addr_top", addr_top, 0);
    chk("restart_frame_start", frame_start, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
